// File: rtl/cp0_regfile.sv
// CP0 architectural state fed by the WB pipe register.
// Count/Compare timer, interrupt request, mfc0 read port.
module cp0_regfile #(
  parameter logic [31:0] EX_ENTRY     = 32'hBFC0_0380,
  parameter logic [31:0] RESET_STATUS = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_rdc,
  input  logic [31:0] cp0_data,
  input  logic        ex_wb,
  input  logic        eret_flush,
  input  logic        branch_delay_wb,
  input  logic [31:0] pc,
  input  logic [4:0]  ex_code,
  input  logic [31:0] badvaddr_in,
  input  logic [5:0]  ext_int,
  input  logic [4:0]  cp0_raddr,
  output logic [31:0] cp0_rdata,
  output logic [31:0] epc,
  output logic [31:0] ex_entry,
  output logic        status_exl,
  output logic        int_req
);

  localparam logic [4:0] R_BADV  = 5'd8;
  localparam logic [4:0] R_COUNT = 5'd9;
  localparam logic [4:0] R_CMP   = 5'd11;
  localparam logic [4:0] R_SR    = 5'd12;
  localparam logic [4:0] R_CAUSE = 5'd13;
  localparam logic [4:0] R_EPC   = 5'd14;

  logic [31:0] badvaddr;
  logic [31:0] count;
  logic [31:0] compare;
  logic [31:0] epc_q;
  logic        tick;
  logic [7:0]  sr_im;
  logic        sr_exl;
  logic        sr_ie;
  logic        cr_bd;
  logic        cr_ti;
  logic [5:0]  cr_ip_hw;
  logic [1:0]  cr_ip_sw;
  logic [4:0]  cr_exc;

  logic wr;
  logic eret;
  logic wr_count;
  logic wr_cmp;
  logic wr_sr;
  logic wr_cause;
  logic wr_epc;
  logic adex;

  // mtc0 and eret are dropped when an exception commits
  always_comb begin
    wr       = cp0_we & ~ex_wb;
    eret     = eret_flush & ~ex_wb;
    wr_count = wr & (cp0_rdc == R_COUNT);
    wr_cmp   = wr & (cp0_rdc == R_CMP);
    wr_sr    = wr & (cp0_rdc == R_SR);
    wr_cause = wr & (cp0_rdc == R_CAUSE);
    wr_epc   = wr & (cp0_rdc == R_EPC);
    adex     = ex_wb &
               ((ex_code == 5'h04) |
                (ex_code == 5'h05));
  end

  // Count runs at half the clock rate
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tick  <= 1'b0;
      count <= '0;
    end else begin
      tick <= ~tick;
      if (wr_count)
        count <= cp0_data;
      else if (tick)
        count <= count + 32'd1;
    end
  end

  // Compare and the sticky timer interrupt
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      compare <= '0;
      cr_ti   <= 1'b0;
    end else begin
      if (wr_cmp) begin
        compare <= cp0_data;
        cr_ti   <= 1'b0;
      end else if (count == compare) begin
        cr_ti <= 1'b1;
      end
    end
  end

  // Status: IM, EXL, IE
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sr_im  <= RESET_STATUS[15:8];
      sr_exl <= RESET_STATUS[1];
      sr_ie  <= RESET_STATUS[0];
    end else begin
      if (wr_sr) begin
        sr_im <= cp0_data[15:8];
        sr_ie <= cp0_data[0];
      end
      if (ex_wb)
        sr_exl <= 1'b1;
      else if (eret)
        sr_exl <= 1'b0;
      else if (wr_sr)
        sr_exl <= cp0_data[1];
    end
  end

  // Cause: pending lines, BD and ExcCode
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cr_ip_hw <= '0;
      cr_ip_sw <= '0;
      cr_bd    <= 1'b0;
      cr_exc   <= '0;
    end else begin
      cr_ip_hw <= {ext_int[5] | cr_ti, ext_int[4:0]};
      if (wr_cause)
        cr_ip_sw <= cp0_data[9:8];
      if (ex_wb) begin
        cr_exc <= ex_code;
        if (!sr_exl)
          cr_bd <= branch_delay_wb;
      end
    end
  end

  // EPC is frozen while already at exception level
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      epc_q <= '0;
    end else if (ex_wb) begin
      if (!sr_exl)
        epc_q <= branch_delay_wb ? pc - 32'd4 : pc;
    end else if (wr_epc) begin
      epc_q <= cp0_data;
    end
  end

  // BadVAddr only captures address errors
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      badvaddr <= '0;
    else if (adex)
      badvaddr <= badvaddr_in;
  end

  // mfc0 read mux
  always_comb begin
    cp0_rdata = '0;
    case (cp0_raddr)
      R_BADV:  cp0_rdata = badvaddr;
      R_COUNT: cp0_rdata = count;
      R_CMP:   cp0_rdata = compare;
      R_SR:    cp0_rdata = {9'b0, 1'b1, 6'b0,
                            sr_im, 6'b0,
                            sr_exl, sr_ie};
      R_CAUSE: cp0_rdata = {cr_bd, cr_ti, 14'b0,
                            cr_ip_hw, cr_ip_sw,
                            1'b0, cr_exc, 2'b0};
      R_EPC:   cp0_rdata = epc_q;
      default: cp0_rdata = '0;
    endcase
  end

  // Side outputs to fetch/decode
  always_comb begin
    epc        = epc_q;
    ex_entry   = EX_ENTRY;
    status_exl = sr_exl;
    int_req    = (|({cr_ip_hw, cr_ip_sw} & sr_im))
                 & sr_ie & ~sr_exl;
  end

endmodule

// File: tb/tb_cp0_regfile.sv
// Randomized bench for cp0_regfile.
// Checks every cycle against a register-level model.
module tb_cp0_regfile;

  logic        clk;
  logic        resetn;
  logic        cp0_we;
  logic [4:0]  cp0_rdc;
  logic [31:0] cp0_data;
  logic        ex_wb;
  logic        eret_flush;
  logic        branch_delay_wb;
  logic [31:0] pc;
  logic [4:0]  ex_code;
  logic [31:0] badvaddr_in;
  logic [5:0]  ext_int;
  logic [4:0]  cp0_raddr;
  logic [31:0] cp0_rdata;
  logic [31:0] epc;
  logic [31:0] ex_entry;
  logic        status_exl;
  logic        int_req;

  int checks;
  int errors;

  logic [31:0] m_bad;
  logic [31:0] m_count;
  logic [31:0] m_cmp;
  logic [31:0] m_sr;
  logic [31:0] m_cr;
  logic [31:0] m_epc;
  logic        m_tick;

  cp0_regfile dut (
    .clk             (clk),
    .resetn          (resetn),
    .cp0_we          (cp0_we),
    .cp0_rdc         (cp0_rdc),
    .cp0_data        (cp0_data),
    .ex_wb           (ex_wb),
    .eret_flush      (eret_flush),
    .branch_delay_wb (branch_delay_wb),
    .pc              (pc),
    .ex_code         (ex_code),
    .badvaddr_in     (badvaddr_in),
    .ext_int         (ext_int),
    .cp0_raddr       (cp0_raddr),
    .cp0_rdata       (cp0_rdata),
    .epc             (epc),
    .ex_entry        (ex_entry),
    .status_exl      (status_exl),
    .int_req         (int_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_bad   = 0;
    m_count = 0;
    m_cmp   = 0;
    m_sr    = 32'h0040_0000;
    m_cr    = 0;
    m_epc   = 0;
    m_tick  = 0;
  endtask

  function automatic logic [31:0] m_read(
    input logic [4:0] a);
    case (a)
      5'd8:    return m_bad;
      5'd9:    return m_count;
      5'd11:   return m_cmp;
      5'd12:   return m_sr;
      5'd13:   return m_cr;
      5'd14:   return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic m_int();
    logic [7:0] pend;
    pend = m_cr[15:8] & m_sr[15:8];
    return (pend != 0) && m_sr[0] && !m_sr[1];
  endfunction

  // One clock of architectural rules
  task automatic model_step();
    logic        ex;
    logic        we;
    logic        er;
    logic [31:0] cnt_n;
    logic [31:0] cmp_n;
    logic [31:0] sr_n;
    logic [31:0] cr_n;
    logic [31:0] epc_n;
    logic [31:0] bad_n;
    ex = ex_wb;
    we = cp0_we && !ex_wb;
    er = eret_flush && !ex_wb;
    cnt_n = m_count + {31'b0, m_tick};
    if (we && cp0_rdc == 9) cnt_n = cp0_data;
    cmp_n = m_cmp;
    if (we && cp0_rdc == 11) cmp_n = cp0_data;
    cr_n = m_cr;
    cr_n[15:10] = {ext_int[5] | m_cr[30],
                   ext_int[4:0]};
    if (we && cp0_rdc == 11) cr_n[30] = 1'b0;
    else if (m_count == m_cmp) cr_n[30] = 1'b1;
    if (we && cp0_rdc == 13)
      cr_n = (cr_n & ~32'h300) | (cp0_data & 32'h300);
    sr_n = m_sr;
    if (we && cp0_rdc == 12)
      sr_n = (m_sr & ~32'hFF03) | (cp0_data & 32'hFF03);
    epc_n = m_epc;
    if (we && cp0_rdc == 14) epc_n = cp0_data;
    bad_n = m_bad;
    if (ex) begin
      if (!m_sr[1]) begin
        cr_n[31] = branch_delay_wb;
        epc_n = branch_delay_wb ? pc - 4 : pc;
      end
      sr_n[1] = 1'b1;
      cr_n[6:2] = ex_code;
      if (ex_code == 4 || ex_code == 5)
        bad_n = badvaddr_in;
    end else if (er) begin
      sr_n[1] = 1'b0;
    end
    m_count = cnt_n;
    m_cmp   = cmp_n;
    m_sr    = sr_n;
    m_cr    = cr_n;
    m_epc   = epc_n;
    m_bad   = bad_n;
    m_tick  = ~m_tick;
  endtask

  task automatic idle();
    cp0_we          = 0;
    cp0_rdc         = 0;
    cp0_data        = 0;
    ex_wb           = 0;
    eret_flush      = 0;
    branch_delay_wb = 0;
    pc              = 0;
    ex_code         = 0;
    badvaddr_in     = 0;
  endtask

  task automatic pick_raddr();
    logic [4:0] tbl [7];
    tbl = '{5'd8, 5'd9, 5'd11, 5'd12,
            5'd13, 5'd14, 5'd0};
    tbl[6] = 5'($urandom_range(0, 31));
    cp0_raddr = tbl[$urandom_range(0, 6)];
  endtask

  // Check outputs, then clock DUT and model
  task automatic step();
    pick_raddr();
    #1;
    chk("rdata", cp0_rdata, m_read(cp0_raddr));
    chk("epc", epc, m_epc);
    chk("exl", {31'b0, status_exl}, {31'b0, m_sr[1]});
    chk("int_req", {31'b0, int_req}, {31'b0, m_int()});
    @(posedge clk);
    if (resetn) model_step();
    @(negedge clk);
  endtask

  task automatic rd(input string tag,
                    input logic [4:0] a,
                    input logic [31:0] exp);
    cp0_raddr = a;
    #1;
    chk(tag, cp0_rdata, exp);
  endtask

  task automatic mtc0(input logic [4:0] r,
                      input logic [31:0] d);
    idle();
    cp0_we   = 1;
    cp0_rdc  = r;
    cp0_data = d;
    step();
    idle();
  endtask

  task automatic exc(input logic [31:0] p,
                     input logic bd,
                     input logic [4:0] code);
    idle();
    ex_wb = 1;
    pc = p;
    branch_delay_wb = bd;
    ex_code = code;
    step();
    idle();
  endtask

  task automatic do_eret();
    idle();
    eret_flush = 1;
    step();
    idle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    resetn = 0;
    ext_int = 0;
    cp0_raddr = 0;
    idle();
    model_reset();
    repeat (2) @(negedge clk);
    rd("rst_sr", 5'd12, 32'h0040_0000);
    rd("rst_epc", 5'd14, 32'h0);
    chk("rst_int", {31'b0, int_req}, 32'h0);
    resetn = 1;
    step();

    exc(32'hBFC0_0100, 1'b0, 5'h08);
    rd("ex_epc", 5'd14, 32'hBFC0_0100);
    chk("ex_code", (cp0_rdata >> 0) & 0, 0);
    rd("ex_cause", 5'd13, m_cr);
    chk("exc8", {27'b0, cp0_rdata[6:2]}, 32'd8);
    chk("bd0", {31'b0, cp0_rdata[31]}, 32'd0);
    chk("exl1", {31'b0, status_exl}, 32'd1);
    chk("entry", ex_entry, 32'hBFC0_0380);
    do_eret();

    exc(32'h8000_0014, 1'b1, 5'h0A);
    rd("bd_epc", 5'd14, 32'h8000_0010);
    cp0_raddr = 5'd13;
    #1;
    chk("bd1", {31'b0, cp0_rdata[31]}, 32'd1);
    exc(32'h1234_5678, 1'b0, 5'h0C);
    rd("nest_epc", 5'd14, 32'h8000_0010);
    do_eret();

    mtc0(5'd9, 32'd0);
    mtc0(5'd12, 32'h0000_8001);
    mtc0(5'd11, 32'd5);
    repeat (14) step();
    cp0_raddr = 5'd13;
    #1;
    chk("ti_set", {31'b0, cp0_rdata[30]}, 32'd1);
    chk("ti_int", {31'b0, int_req}, 32'd1);
    mtc0(5'd11, 32'd100);
    repeat (2) step();
    cp0_raddr = 5'd13;
    #1;
    chk("ti_clr", {31'b0, cp0_rdata[30]}, 32'd0);
    chk("ti_noint", {31'b0, int_req}, 32'd0);

    mtc0(5'd12, 32'h0000_0401);
    ext_int = 6'b000001;
    step();
    chk("ext_int", {31'b0, int_req}, 32'd1);
    exc(32'h2000, 1'b0, 5'h00);
    chk("ext_exl", {31'b0, int_req}, 32'd0);
    do_eret();
    chk("ext_eret", {31'b0, int_req}, 32'd1);
    ext_int = 0;

    idle();
    ex_wb = 1;
    pc = 32'h1000;
    ex_code = 5'h04;
    badvaddr_in = 32'h1003;
    cp0_we = 1;
    cp0_rdc = 5'd14;
    cp0_data = 32'hDEAD_BEEF;
    step();
    idle();
    rd("pri_epc", 5'd14, 32'h1000);
    rd("badv", 5'd8, 32'h1003);
    do_eret();

    mtc0(5'd9, 32'd30);
    repeat (14) step();
    exc(32'h3000, 1'b0, 5'h08);
    #2;
    resetn = 0;
    #1;
    model_reset();
    chk("ar_exl", {31'b0, status_exl}, 32'd0);
    chk("ar_epc", epc, 32'd0);
    chk("ar_int", {31'b0, int_req}, 32'd0);
    rd("ar_cnt", 5'd9, 32'd0);
    rd("ar_sr", 5'd12, 32'h0040_0000);
    rd("ar_cause", 5'd13, 32'd0);
    @(negedge clk);
    resetn = 1;
    mtc0(5'd12, 32'hFFFF_FFFF);
    rd("sr_mask", 5'd12, 32'h0040_FF03);
    mtc0(5'd12, 32'h0);

    for (int i = 0; i < 400; i++) begin
      logic [4:0] rtab [7];
      logic [4:0] ctab [4];
      rtab = '{5'd8, 5'd9, 5'd11, 5'd12,
               5'd13, 5'd14, 5'd3};
      ctab = '{5'h04, 5'h05, 5'h08, 5'h0C};
      idle();
      if ($urandom_range(0, 3) == 0) begin
        cp0_we = 1;
        cp0_rdc = rtab[$urandom_range(0, 6)];
        cp0_data = $urandom;
        if (cp0_rdc == 11 && $urandom_range(0, 1) == 1)
          cp0_data = m_count + $urandom_range(0, 6);
      end
      if ($urandom_range(0, 15) == 0) begin
        ex_wb = 1;
        ex_code = ctab[$urandom_range(0, 3)];
        pc = $urandom;
        branch_delay_wb = 1'($urandom);
        badvaddr_in = $urandom;
      end
      if ($urandom_range(0, 9) == 0)
        eret_flush = 1;
      if ($urandom_range(0, 7) == 0)
        ext_int = 6'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
